// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL acquisition controller.
//   pll_state_t    : controller state encoding
//   FREQ_W         : width of the VCO/DDS phase-increment word
//   CNT_W          : width of the dwell/lock/loss counters
//   SWEEP_W        : width of the sweep counter
//   DEF_*          : parameter defaults used by pll_acq_ctrl and pll_step_gen
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DWELL   = 3'd1,
        S_CONFIRM = 3'd2,
        S_TRACK   = 3'd3,
        S_FAIL    = 3'd4
    } pll_state_t;

    localparam int FREQ_W  = 16;
    localparam int CNT_W   = 16;
    localparam int SWEEP_W = 8;

    localparam logic [FREQ_W-1:0] DEF_F_START = 16'd1000;
    localparam logic [FREQ_W-1:0] DEF_F_STOP  = 16'd3000;
    localparam logic [FREQ_W-1:0] DEF_F_STEP  = 16'd16;

    localparam int DEF_DWELL      = 8;
    localparam int DEF_LOCK_CNT   = 16;
    localparam int DEF_LOSS_CNT   = 4;
    localparam int DEF_MAX_SWEEPS = 3;

endpackage

// File: rtl/pll_step_gen.sv
// Next-frequency generator for the acquisition sweep.
// Ports:
//   freq_base  in  : current coarse phase increment
//   sweep_num  in  : number of completed sweeps
//   next_freq  out : frequency to use after a dwell expires
//   wrap       out : the step would overshoot F_STOP, so the sweep restarts at F_START
//   last_wrap  out : wrap on the final permitted sweep (acquisition has failed)
module pll_step_gen
    import pll_ctrl_pkg::*;
#(
    parameter logic [FREQ_W-1:0] F_START    = DEF_F_START,
    parameter logic [FREQ_W-1:0] F_STOP     = DEF_F_STOP,
    parameter logic [FREQ_W-1:0] F_STEP     = DEF_F_STEP,
    parameter int                MAX_SWEEPS = DEF_MAX_SWEEPS
) (
    input  logic [FREQ_W-1:0]  freq_base,
    input  logic [SWEEP_W-1:0] sweep_num,
    output logic [FREQ_W-1:0]  next_freq,
    output logic               wrap,
    output logic               last_wrap
);

    // One extra bit so a step near the top of the 16-bit range cannot
    // alias back below F_STOP.
    logic [FREQ_W:0] w_sum;

    assign w_sum     = {1'b0, freq_base} + {1'b0, F_STEP};
    assign wrap      = (w_sum > {1'b0, F_STOP});
    assign last_wrap = wrap && (sweep_num == SWEEP_W'(MAX_SWEEPS - 1));
    assign next_freq = wrap ? F_START : w_sum[FREQ_W-1:0];

endmodule

// File: rtl/pll_acq_ctrl.sv
// PLL acquisition controller: sweeps the coarse VCO frequency from F_START
// towards F_STOP, dwelling DWELL ticks per point, confirms lock over LOCK_CNT
// consecutive lock ticks, tracks until LOSS_CNT consecutive unlock ticks,
// and gives up after MAX_SWEEPS full sweeps.
// Ports:
//   clk_500   in  : loop update clock (one tick per cycle)
//   rst_n     in  : asynchronous active-low reset
//   start     in  : one-cycle request to begin acquisition (IDLE/FAIL only)
//   abort     in  : level request to return to IDLE, highest priority
//   lock_in   in  : per-tick phase-error-small flag
//   freq_base out : coarse phase increment for the VCO/DDS
//   loop_en   out : VCO phase accumulator enable
//   loop_clr  out : one-cycle loop-filter integrator clear
//   acquired  out : lock confirmed and being tracked
//   fail      out : all sweeps exhausted without lock
//   busy      out : acquisition or tracking in progress
module pll_acq_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter logic [FREQ_W-1:0] F_START    = DEF_F_START,
    parameter logic [FREQ_W-1:0] F_STOP     = DEF_F_STOP,
    parameter logic [FREQ_W-1:0] F_STEP     = DEF_F_STEP,
    parameter int                DWELL      = DEF_DWELL,
    parameter int                LOCK_CNT   = DEF_LOCK_CNT,
    parameter int                LOSS_CNT   = DEF_LOSS_CNT,
    parameter int                MAX_SWEEPS = DEF_MAX_SWEEPS
) (
    input  logic              clk_500,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              lock_in,
    output logic [FREQ_W-1:0] freq_base,
    output logic              loop_en,
    output logic              loop_clr,
    output logic              acquired,
    output logic              fail,
    output logic              busy
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST  = CNT_W'(LOSS_CNT - 1);

    pll_state_t          r_state;
    logic [FREQ_W-1:0]   r_freq_base;
    logic [SWEEP_W-1:0]  r_sweep_num;
    logic [CNT_W-1:0]    r_dwell_cnt;
    logic [CNT_W-1:0]    r_lock_cnt;
    logic [CNT_W-1:0]    r_loss_cnt;
    logic                r_loop_en;
    logic                r_loop_clr;
    logic                r_acquired;
    logic                r_fail;
    logic                r_busy;

    pll_state_t          w_state;
    logic [FREQ_W-1:0]   w_freq_base;
    logic [SWEEP_W-1:0]  w_sweep_num;
    logic [CNT_W-1:0]    w_dwell_cnt;
    logic [CNT_W-1:0]    w_lock_cnt;
    logic [CNT_W-1:0]    w_loss_cnt;
    logic                w_loop_en;
    logic                w_loop_clr;
    logic                w_acquired;
    logic                w_fail;
    logic                w_busy;
    logic                w_clr_req;
    logic                w_advance;

    logic [FREQ_W-1:0]   w_next_freq;
    logic                w_wrap;
    logic                w_last_wrap;

    pll_step_gen #(
        .F_START    (F_START),
        .F_STOP     (F_STOP),
        .F_STEP     (F_STEP),
        .MAX_SWEEPS (MAX_SWEEPS)
    ) u_step_gen (
        .freq_base  (r_freq_base),
        .sweep_num  (r_sweep_num),
        .next_freq  (w_next_freq),
        .wrap       (w_wrap),
        .last_wrap  (w_last_wrap)
    );

    always_ff @(posedge clk_500 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_freq_base <= '0;
            r_sweep_num <= '0;
            r_dwell_cnt <= '0;
            r_lock_cnt  <= '0;
            r_loss_cnt  <= '0;
            r_loop_en   <= 1'b0;
            r_loop_clr  <= 1'b0;
            r_acquired  <= 1'b0;
            r_fail      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_freq_base <= w_freq_base;
            r_sweep_num <= w_sweep_num;
            r_dwell_cnt <= w_dwell_cnt;
            r_lock_cnt  <= w_lock_cnt;
            r_loss_cnt  <= w_loss_cnt;
            r_loop_en   <= w_loop_en;
            r_loop_clr  <= w_loop_clr;
            r_acquired  <= w_acquired;
            r_fail      <= w_fail;
            r_busy      <= w_busy;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_freq_base = r_freq_base;
        w_sweep_num = r_sweep_num;
        w_dwell_cnt = r_dwell_cnt;
        w_lock_cnt  = r_lock_cnt;
        w_loss_cnt  = r_loss_cnt;
        w_loop_en   = r_loop_en;
        w_acquired  = r_acquired;
        w_fail      = r_fail;
        w_busy      = r_busy;
        w_clr_req   = 1'b0;
        w_advance   = 1'b0;

        if (abort) begin
            w_state    = S_IDLE;
            w_loop_en  = 1'b0;
            w_acquired = 1'b0;
            w_fail     = 1'b0;
            w_busy     = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_FAIL: begin
                    if (start) begin
                        w_state     = S_DWELL;
                        w_freq_base = F_START;
                        w_sweep_num = '0;
                        w_dwell_cnt = '0;
                        w_lock_cnt  = '0;
                        w_loss_cnt  = '0;
                        w_fail      = 1'b0;
                        w_acquired  = 1'b0;
                        w_loop_en   = 1'b1;
                        w_busy      = 1'b1;
                        w_clr_req   = 1'b1;
                    end
                end
                S_DWELL: begin
                    if (lock_in) begin
                        w_state    = S_CONFIRM;
                        w_lock_cnt = CNT_W'(1);
                    end else begin
                        w_advance = 1'b1;
                    end
                end
                S_CONFIRM: begin
                    // dwell_cnt stays frozen while lock is being confirmed.
                    if (lock_in) begin
                        if (r_lock_cnt == LOCK_LAST) begin
                            w_state    = S_TRACK;
                            w_acquired = 1'b1;
                            w_loss_cnt = '0;
                        end else begin
                            w_lock_cnt = r_lock_cnt + CNT_W'(1);
                        end
                    end else begin
                        // A broken confirm still consumes a dwell tick, so a
                        // flickering lock cannot stall the sweep forever.
                        w_state   = S_DWELL;
                        w_advance = 1'b1;
                    end
                end
                S_TRACK: begin
                    if (lock_in) begin
                        w_loss_cnt = '0;
                    end else if (r_loss_cnt == LOSS_LAST) begin
                        // Re-acquire from the frequency we were tracking at.
                        w_state     = S_DWELL;
                        w_acquired  = 1'b0;
                        w_sweep_num = '0;
                        w_dwell_cnt = '0;
                        w_loss_cnt  = '0;
                        w_clr_req   = 1'b1;
                    end else begin
                        w_loss_cnt = r_loss_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state   = S_IDLE;
                    w_loop_en = 1'b0;
                    w_busy    = 1'b0;
                end
            endcase

            // Shared dwell bookkeeping for an unlocked tick in DWELL/CONFIRM.
            if (w_advance) begin
                if (r_dwell_cnt == DWELL_LAST) begin
                    w_dwell_cnt = '0;
                    if (w_last_wrap) begin
                        w_state   = S_FAIL;
                        w_fail    = 1'b1;
                        w_loop_en = 1'b0;
                        w_busy    = 1'b0;
                    end else begin
                        w_freq_base = w_next_freq;
                        if (w_wrap) begin
                            w_sweep_num = r_sweep_num + SWEEP_W'(1);
                        end
                        w_clr_req = 1'b1;
                    end
                end else begin
                    w_dwell_cnt = r_dwell_cnt + CNT_W'(1);
                end
            end
        end

        // Suppress back-to-back clears (only reachable with very short dwells).
        w_loop_clr = w_clr_req && !r_loop_clr;
    end

    assign freq_base = r_freq_base;
    assign loop_en   = r_loop_en;
    assign loop_clr  = r_loop_clr;
    assign acquired  = r_acquired;
    assign fail      = r_fail;
    assign busy      = r_busy;

endmodule
